// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_param (slave).
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered read port, registered occupancy/threshold flags
// and sticky overflow/underflow indicators.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wa, ra;

  always_comb begin
    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    ra = fifo.rd_en & ~empty_q;
    wa = fifo.wr_en & (~full_q | ra);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (wa) wr_ptr_d = wr_ptr_q + AW'(1);
    if (ra) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    unique case ({wa, ra})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    ovf_d = ovf_q | (fifo.wr_en & ~wa);
    unf_d = unf_q | (fifo.rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is not cleared on reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wa) mem_q[wr_ptr_q] <= fifo.wr_data;
  end

  assign fifo.rd_data      = rd_data_q;
  assign fifo.rd_valid     = rd_valid_q;
  assign fifo.full         = full_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.almost_empty = aempty_q;
  assign fifo.count        = count_q;
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sync_fifo_param;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered queue of stored words plus the observable read/error state.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_rd_data  = '0;
  logic          m_rd_valid = 1'b0;
  logic          m_ovf      = 1'b0;
  logic          m_unf      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      automatic int  sz = mq.size();
      automatic bit  r_ok = bus.rd_en && (sz > 0);
      automatic bit  w_ok = bus.wr_en && ((sz < DEPTH) || r_ok);
      if (bus.rd_en && sz == 0) m_unf = 1'b1;
      if (bus.wr_en && !w_ok)   m_ovf = 1'b1;
      m_rd_valid = r_ok;
      if (r_ok) m_rd_data = mq.pop_front();
      if (w_ok) mq.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int sz = mq.size();
      check("m.rd_data",  32'(bus.rd_data),      32'(m_rd_data));
      check("m.rd_valid", 32'(bus.rd_valid),     32'(m_rd_valid));
      check("m.count",    32'(bus.count),        32'(sz));
      check("m.full",     32'(bus.full),         32'(sz == DEPTH));
      check("m.empty",    32'(bus.empty),        32'(sz == 0));
      check("m.afull",    32'(bus.almost_full),  32'(sz >= AF));
      check("m.aempty",   32'(bus.almost_empty), 32'(sz <= AE));
      check("m.overflow", 32'(bus.overflow),     32'(m_ovf));
      check("m.underflow",32'(bus.underflow),    32'(m_unf));
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b1;
    step(w, 16'hAAAA, r);
    rst = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    check("rst.count",  32'(bus.count), 32'd0);
    check("rst.empty",  32'(bus.empty), 32'd1);
    check("rst.aempty", 32'(bus.almost_empty), 32'd1);
    check("rst.full",   32'(bus.full), 32'd0);
    check("rst.flags",  32'({bus.almost_full, bus.overflow, bus.underflow, bus.rd_valid}), 32'd0);
    check("rst.rd_data",32'(bus.rd_data), 32'd0);

    // Underflow right after reset
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    check("unf.flag",   32'(bus.underflow), 32'd1);
    check("unf.valid",  32'(bus.rd_valid), 32'd0);
    check("unf.data",   32'(bus.rd_data), 32'd0);
    check("unf.count",  32'(bus.count), 32'd0);

    // Requests during reset are discarded and raise no errors
    do_reset(1'b1, 1'b1);
    check("rstreq.count", 32'(bus.count), 32'd0);
    check("rstreq.err",   32'({bus.overflow, bus.underflow}), 32'd0);

    // Fill and drain
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 16'(i), 1'b0);
      check("fill.count", 32'(bus.count), 32'(i));
      check("fill.afull", 32'(bus.almost_full), 32'(i >= 14));
    end
    check("fill.full", 32'(bus.full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain.valid", 32'(bus.rd_valid), 32'd1);
      check("drain.data",  32'(bus.rd_data), 32'(i));
    end
    check("drain.empty", 32'(bus.empty), 32'd1);
    step(1'b0, '0, 1'b0);
    check("hold.valid", 32'(bus.rd_valid), 32'd0);
    check("hold.data",  32'(bus.rd_data), 32'h0010);

    // Overflow while full
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    check("ovf.flag",  32'(bus.overflow), 32'd1);
    check("ovf.count", 32'(bus.count), 32'd16);
    step(1'b0, '0, 1'b0);
    check("ovf.sticky", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("ovf.data", 32'(bus.rd_data), 32'h0100 + 32'(i));
    end
    check("ovf.empty", 32'(bus.empty), 32'd1);

    // Simultaneous write and read while full
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b1);
    check("sim.data",  32'(bus.rd_data), 32'h0201);
    check("sim.count", 32'(bus.count), 32'd16);
    check("sim.ovf",   32'(bus.overflow), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("sim.drain", 32'(bus.rd_data), 32'h0200 + 32'(i));
    end
    step(1'b0, '0, 1'b1);
    check("sim.beef", 32'(bus.rd_data), 32'hBEEF);

    // Write on empty with read request: no bypass
    do_reset(1'b0, 1'b0);
    step(1'b1, 16'h0077, 1'b1);
    check("wre.count", 32'(bus.count), 32'd1);
    check("wre.valid", 32'(bus.rd_valid), 32'd0);
    check("wre.unf",   32'(bus.underflow), 32'd1);
    step(1'b0, '0, 1'b1);
    check("wre.data",  32'(bus.rd_data), 32'h0077);

    // Alternating write/read pairs across two pointer wraps
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 16'h0300 + 16'(k), 1'b0);
      check("wrap.cnt1", 32'(bus.count), 32'd1);
      step(1'b0, '0, 1'b1);
      check("wrap.data", 32'(bus.rd_data), 32'h0300 + 32'(k));
      check("wrap.cnt0", 32'(bus.count), 32'd0);
    end
    check("wrap.err", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Reset mid-operation
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0);
    check("mid.pre", 32'(bus.count), 32'd7);
    do_reset(1'b1, 1'b0);
    check("mid.count", 32'(bus.count), 32'd0);
    check("mid.empty", 32'(bus.empty), 32'd1);
    check("mid.err",   32'({bus.overflow, bus.underflow}), 32'd0);
    step(1'b1, 16'h0555, 1'b0);
    check("mid.first", 32'(bus.count), 32'd1);
    step(1'b0, '0, 1'b1);
    check("mid.data",  32'(bus.rd_data), 32'h0555);
    check("mid.empty2",32'(bus.empty), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each stored word (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty asserts (1..DEPTH-1).
REQ-005 Localparam AW = log2(DEPTH); CW = AW+1.
REQ-006 clk  input  1  clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_data  output  DATA_WIDTH  registered read word.
REQ-012 rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
REQ-013 full, empty  output  1 each  occupancy flags, registered.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags, registered.
REQ-015 count  output  CW  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage: DEPTH x DATA_WIDTH array; wr_ptr, rd_ptr each AW bits, wrap DEPTH-1 -> 0 naturally.
REQ-018 Write accepted (wa) = wr_en & (!full | ra); accepted word stored at wr_ptr, wr_ptr+1.
REQ-019 Read accepted (ra) = rd_en & !empty; mem[rd_ptr] loaded to rd_data next edge, rd_ptr+1, rd_valid=1 that cycle.
REQ-020 Read latency: exactly 1 clock from accepted rd_en to rd_valid/rd_data.
REQ-021 rd_data holds last value when no read accepted; rd_valid=0 in those cycles.
REQ-022 Simultaneous wa & ra: both pointers advance, count unchanged, flags unchanged.
REQ-023 Write while full with simultaneous accepted read: write accepted (no loss), count stays DEPTH.
REQ-024 Write on empty with simultaneous rd_en: read rejected (no bypass), write accepted, count 0->1, underflow set.
REQ-025 count: +1 on wa only, -1 on ra only, else unchanged; never exceeds DEPTH nor below 0.
REQ-026 full = (count==DEPTH), empty = (count==0); both derived from next-count, valid same edge as count.
REQ-027 almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); registered with count.
REQ-028 overflow set when wr_en=1 and write not accepted; underflow set when rd_en=1 and empty; both stay set until rst.
REQ-029 Rejected requests change no pointer, count, memory, or rd_data.
REQ-030 Data ordering strictly first-in first-out across pointer wrap-around.

Reset
REQ-031 On rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0.
REQ-032 On reset: empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-033 rst dominates wr_en/rd_en in the same cycle; requests during rst are discarded, no error flags set.
REQ-034 Reset mid-operation discards all stored contents; memory array itself need not be cleared.
REQ-035 First operation is accepted in the cycle immediately following rst deassertion.

Verification (DATA_WIDTH=16, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-036 Fill/drain: write 0x0001..0x0010 in 16 cycles -> full=1, count=16, almost_full from count 14; then read 16 -> rd_data 0x0001..0x0010 in order, each 1 cycle after rd_en, empty=1 after last.
REQ-037 Overflow: full, wr_en=1 rd_en=0 with 0xDEAD -> overflow=1 sticky, count=16, 0xDEAD never read out.
REQ-038 Underflow: after reset rd_en=1 -> underflow=1, rd_valid=0, rd_data=0x0000, count=0.
REQ-039 Simultaneous: count=16, wr_en=rd_en=1 with 0xBEEF -> read returns oldest word, count stays 16; 0xBEEF emerges 16 reads later.
REQ-040 Wrap: 40 cycles alternating write/read pairs -> pointers wrap twice, data in order, count toggles 0/1, no error flags.
REQ-041 Reset mid-op: count=7, assert rst with wr_en=1 -> next cycle count=0, empty=1, overflow=underflow=0, later read returns newly written data only.
